data_memory_mmio: RTL and testbench

DATA_MEMORY_MMIO -- requirements
Module: data_memory_mmio

---
 rtl/data_memory_mmio_pkg.sv | 31 +++
 rtl/data_memory_mmio_regs.sv | 101 ++++++++++
 rtl/data_memory_mmio.sv | 74 +++++++
 tb/tb_data_memory_mmio.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_mmio_pkg.sv
// Purpose: shared constants and helpers for the data memory with memory-mapped IO window.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package data_memory_mmio_pkg;

  // The IO window occupies the top IO_WINDOW word addresses of the memory map.
  localparam int IO_WINDOW = 16;

  // Word offsets inside the IO window (address[3:0]).
  localparam logic [3:0] OFF_IN_DATA    = 4'd0;
  localparam logic [3:0] OFF_IN_CHANGED = 4'd1;
  localparam logic [3:0] OFF_OUT_BASE   = 4'd2;
  localparam logic [3:0] OFF_CYCLE      = 4'd15;

  // OUT words may fill offsets 2..14 at most.
  localparam int MAX_OUT_WORDS = 13;

  function automatic int out_words(input int width);
    return (width + 31) / 32;
  endfunction

  // Expand a 4-bit byte enable into a 32-bit bit mask.
  function automatic logic [31:0] byte_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = {8{be[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/data_memory_mmio_regs.sv
// Purpose: IO register file (IN_DATA, IN_CHANGED, OUT words, CYCLE) with a 2-FF input synchroniser.
// Latency: rd_data is combinational on offset; writes and io_output_bus update at the accepting edge.
// Backpressure: none; every write is accepted in the cycle it is presented.
//
// Ports: clock/reset (async, active-high); wr_en/offset/byteena/data form the write port for
// the IO window; rd_data is the current value of the addressed register; io_input_bus is
// asynchronous external input; io_output_bus is driven directly from the OUT word registers.
module mmio_regs
  import data_memory_mmio_pkg::*;
#(
  parameter int IO_IN_WIDTH  = 14,
  parameter int IO_OUT_WIDTH = 52
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [3:0]              offset,
  input  logic [3:0]              byteena,
  input  logic [31:0]             data,
  output logic [31:0]             rd_data,
  input  logic [IO_IN_WIDTH-1:0]  io_input_bus,
  output logic [IO_OUT_WIDTH-1:0] io_output_bus
);

  localparam int N_OUT = out_words(IO_OUT_WIDTH);

  if (N_OUT > MAX_OUT_WORDS || IO_IN_WIDTH > 32 || IO_IN_WIDTH < 1 || IO_OUT_WIDTH < 1) begin : g_bad_width
    $error("mmio_regs: IO widths out of range (IO_IN_WIDTH 1..32, IO_OUT_WIDTH 1..416)");
  end

  logic [IO_IN_WIDTH-1:0] sync1, sync2, sync_prev;
  logic [IO_IN_WIDTH-1:0] in_changed, chg_clr;
  logic [31:0]            cycle_cnt;
  logic [31:0]            wmask;
  logic [31:0]            out_rd [N_OUT];

  assign wmask = byte_mask(byteena);

  // W1C: only the enabled bytes of the write data can clear bits.
  always_comb begin
    chg_clr = '0;
    if (wr_en && offset == OFF_IN_CHANGED) begin
      chg_clr = IO_IN_WIDTH'(data & wmask);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1      <= '0;
      sync2      <= '0;
      sync_prev  <= '0;
      in_changed <= '0;
      cycle_cnt  <= '0;
    end else begin
      sync1      <= io_input_bus;
      sync2      <= sync1;
      sync_prev  <= sync2;
      // The set term is OR-ed in after the clear, so a same-cycle edge survives a W1C.
      in_changed <= (in_changed & ~chg_clr) | (sync2 ^ sync_prev);
      cycle_cnt  <= cycle_cnt + 32'd1;
    end
  end

  // Each OUT word stores only the bits that reach io_output_bus, so unused
  // upper bits of the last word read back as zero without extra masking.
  for (genvar k = 0; k < N_OUT; k++) begin : g_out
    localparam int W = (IO_OUT_WIDTH - 32*k >= 32) ? 32 : IO_OUT_WIDTH - 32*k;
    logic [W-1:0] word_q;
    logic         hit;

    assign hit = (offset == OFF_OUT_BASE + 4'(k));

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        word_q <= '0;
      end else if (wr_en && hit) begin
        word_q <= (word_q & ~wmask[W-1:0]) | (data[W-1:0] & wmask[W-1:0]);
      end
    end

    assign out_rd[k]                 = hit ? 32'(word_q) : 32'd0;
    assign io_output_bus[32*k +: W]  = word_q;
  end

  always_comb begin
    rd_data = '0;
    if (offset == OFF_IN_DATA) begin
      rd_data[IO_IN_WIDTH-1:0] = sync2;
    end else if (offset == OFF_IN_CHANGED) begin
      rd_data[IO_IN_WIDTH-1:0] = in_changed;
    end else if (offset == OFF_CYCLE) begin
      rd_data = cycle_cnt;
    end else begin
      // At most one OUT word matches; unmapped offsets leave this at zero.
      for (int k = 0; k < N_OUT; k++) begin
        rd_data = rd_data | out_rd[k];
      end
    end
  end

endmodule

// File: rtl/data_memory_mmio.sv
// Purpose: word-addressed 32-bit data RAM with byte enables and a 16-word IO window at the top.
// Latency: q is registered, one cycle after the address edge; read-during-write returns the old value.
// Backpressure: none; a read or write is accepted every cycle.
//
// Ports: clock/reset (async, active-high); address/byteena/data/wren is the access port;
// q is the registered read data; io_input_bus/io_output_bus are the external IO pins.
module data_memory_mmio
  import data_memory_mmio_pkg::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter int IO_IN_WIDTH  = 14,
  parameter int IO_OUT_WIDTH = 52
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [3:0]              byteena,
  input  logic [31:0]             data,
  input  logic                    wren,
  output logic [31:0]             q,
  input  logic [IO_IN_WIDTH-1:0]  io_input_bus,
  output logic [IO_OUT_WIDTH-1:0] io_output_bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if (ADDR_WIDTH < 5) begin : g_bad_addr
    $error("data_memory_mmio: ADDR_WIDTH must leave room for the 16-word IO window");
  end

  logic        in_io;
  logic [31:0] io_rd;
  logic [31:0] mem [DEPTH];

  assign in_io = (address >= ADDR_WIDTH'(DEPTH - IO_WINDOW));

  mmio_regs #(
    .IO_IN_WIDTH  (IO_IN_WIDTH),
    .IO_OUT_WIDTH (IO_OUT_WIDTH)
  ) u_regs (
    .clock         (clock),
    .reset         (reset),
    .wr_en         (wren & in_io),
    .offset        (address[3:0]),
    .byteena       (byteena),
    .data          (data),
    .rd_data       (io_rd),
    .io_input_bus  (io_input_bus),
    .io_output_bus (io_output_bus)
  );

  // RAM has no reset so it infers as block memory; the reset term only
  // cancels a write whose edge lands while reset is held.
  always_ff @(posedge clock) begin
    if (wren && !in_io && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (byteena[b]) begin
          mem[address][8*b +: 8] <= data[8*b +: 8];
        end
      end
    end
  end

  // Sampling address here captures the pre-write contents of both RAM and IO
  // registers, which gives old-data read-during-write for free.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else begin
      q <= in_io ? io_rd : mem[address];
    end
  end

endmodule

// File: tb/tb_data_memory_mmio.sv
module tb_data_memory_mmio;

  localparam int AW = 10;
  localparam int IW = 14;
  localparam int OW = 52;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] address;
  logic [3:0]    byteena;
  logic [31:0]   data;
  logic          wren;
  logic [31:0]   q;
  logic [IW-1:0] io_input_bus;
  logic [OW-1:0] io_output_bus;

  int checks   = 0;
  int failures = 0;

  // Reference model: abstract memory map, not register-level structure.
  logic [31:0]   ram_m [16];
  logic [3:0]    ram_v [16];
  logic [31:0]   out_m [2];
  logic [IW-1:0] chg_m;
  logic [IW-1:0] hist1, hist2, hist3;  // input value presented 1, 2, 3 edges ago
  logic [IW-1:0] in_drv;
  logic [31:0]   cyc_m;
  logic [31:0]   saved;

  data_memory_mmio #(.ADDR_WIDTH(AW), .IO_IN_WIDTH(IW), .IO_OUT_WIDTH(OW)) dut (
    .clock         (clock),
    .reset         (reset),
    .address       (address),
    .byteena       (byteena),
    .data          (data),
    .wren          (wren),
    .q             (q),
    .io_input_bus  (io_input_bus),
    .io_output_bus (io_output_bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bmask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  function automatic logic [31:0] io_model_read(input logic [3:0] off);
    case (off)
      4'd0:    return {18'd0, hist2};
      4'd1:    return {18'd0, chg_m};
      4'd2:    return out_m[0];
      4'd3:    return out_m[1];
      4'd15:   return cyc_m;
      default: return 32'd0;
    endcase
  endfunction

  task automatic reset_model();
    out_m[0] = '0; out_m[1] = '0;
    chg_m = '0; hist1 = '0; hist2 = '0; hist3 = '0;
    cyc_m = '0;
  endtask

  // Drive one access at the falling edge, predict across the rising edge,
  // then check q and io_output_bus at the next falling edge.
  task automatic step(input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] d, input logic w);
    logic [31:0]   exp_q;
    logic          known;
    logic [31:0]   bm;
    logic [IW-1:0] clr;
    address = a; byteena = be; data = d; wren = w; io_input_bus = in_drv;
    @(posedge clock);
    exp_q = 32'd0;
    known = 1'b1;
    bm    = bmask(be);
    if (!reset) begin
      if (a >= 10'd1008) begin
        exp_q = io_model_read(a[3:0]);
      end else if (a < 10'd16) begin
        exp_q = ram_m[a[3:0]];
        known = (ram_v[a[3:0]] == 4'hF);
      end else begin
        known = 1'b0;
      end
      clr = '0;
      if (w && a >= 10'd1008) begin
        case (a[3:0])
          4'd1:    clr = bm[IW-1:0] & d[IW-1:0];
          4'd2:    out_m[0] = (out_m[0] & ~bm) | (d & bm);
          4'd3:    out_m[1] = ((out_m[1] & ~bm) | (d & bm)) & 32'h000F_FFFF;
          default: ;
        endcase
      end else if (w && a < 10'd16) begin
        ram_m[a[3:0]] = (ram_m[a[3:0]] & ~bm) | (d & bm);
        ram_v[a[3:0]] = ram_v[a[3:0]] | be;
      end
      chg_m = (chg_m & ~clr) | (hist2 ^ hist3);
      hist3 = hist2; hist2 = hist1; hist1 = in_drv;
      cyc_m = cyc_m + 32'd1;
    end
    @(negedge clock);
    if (known) chk("q_model", {32'd0, q}, {32'd0, exp_q});
    chk("bus_model", {12'd0, io_output_bus}, {12'd0, out_m[1][19:0], out_m[0]});
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin ram_m[i] = '0; ram_v[i] = '0; end
    in_drv = '0;
    reset_model();
    reset = 1'b1;
    address = '0; byteena = '0; data = '0; wren = 1'b0; io_input_bus = '0;
    @(negedge clock);
    @(negedge clock);
    chk("reset_q", {32'd0, q}, 64'd0);
    chk("reset_bus", {12'd0, io_output_bus}, 64'd0);
    reset = 1'b0;

    // CYCLE reads 0 at the first edge after reset release.
    step(10'h3FF, 4'h0, 32'd0, 1'b0);
    chk("cycle_first", {32'd0, q}, 64'd0);
    step(10'h3FF, 4'h0, 32'd0, 1'b0);
    chk("cycle_second", {32'd0, q}, 64'd1);

    // Byte-enable partial write.
    step(10'd5, 4'hF, 32'h1111_2222, 1'b1);
    step(10'd5, 4'h3, 32'hDEAD_BEEF, 1'b1);
    step(10'd5, 4'h0, 32'd0, 1'b0);
    chk("ram_byteena", {32'd0, q}, {32'd0, 32'h1111_BEEF});

    // OUT words drive the bus; unused top bits of word 1 read back as zero.
    step(10'h3F2, 4'hF, 32'h1234_5678, 1'b1);
    chk("bus_after_out0", {12'd0, io_output_bus}, 64'h0000_0000_1234_5678);
    step(10'h3F3, 4'hF, 32'hFFFF_FFFF, 1'b1);
    chk("bus_after_out1", {12'd0, io_output_bus}, 64'h000F_FFFF_1234_5678);
    step(10'h3F3, 4'h0, 32'd0, 1'b0);
    chk("out1_readback", {32'd0, q}, 64'h0000_0000_000F_FFFF);

    // Input bit 3 rises: IN_DATA follows two edges later, IN_CHANGED flags it.
    in_drv = 14'h0008;
    step(10'h3F0, 4'h0, 32'd0, 1'b0);
    chk("in_data_lag0", {32'd0, q}, 64'd0);
    step(10'h3F0, 4'h0, 32'd0, 1'b0);
    chk("in_data_lag1", {32'd0, q}, 64'd0);
    step(10'h3F0, 4'h0, 32'd0, 1'b0);
    chk("in_data_set", {32'd0, q}, 64'h8);
    step(10'h3F1, 4'h0, 32'd0, 1'b0);
    chk("in_changed_set", {32'd0, q}, 64'h8);
    step(10'h3F1, 4'hF, 32'h0000_0008, 1'b1);
    step(10'h3F1, 4'h0, 32'd0, 1'b0);
    chk("in_changed_w1c", {32'd0, q}, 64'd0);

    // Input falls; clear lands on the same edge the change is flagged.
    in_drv = 14'h0000;
    step(10'h3F0, 4'h0, 32'd0, 1'b0);
    step(10'h3F0, 4'h0, 32'd0, 1'b0);
    step(10'h3F1, 4'hF, 32'h0000_0008, 1'b1);
    step(10'h3F1, 4'h0, 32'd0, 1'b0);
    chk("set_over_clear", {32'd0, q}, 64'h8);

    // Writes into the IO window never reach RAM.
    saved = dut.mem[1023];
    step(10'h3FF, 4'hF, ~saved, 1'b1);
    step(10'h3FF, 4'h0, 32'd0, 1'b0);
    chk("ram_top_untouched", {32'd0, dut.mem[1023]}, {32'd0, saved});

    // Same-word read and write returns the old data.
    step(10'd9, 4'hF, 32'h0000_000A, 1'b1);
    step(10'd9, 4'hF, 32'h0000_000B, 1'b1);
    chk("rdw_old", {32'd0, q}, 64'hA);
    step(10'd9, 4'h0, 32'd0, 1'b0);
    chk("rdw_new", {32'd0, q}, 64'hB);

    // Randomised traffic over low RAM and the whole IO window.
    for (int i = 0; i < 400; i++) begin
      logic [AW-1:0] a;
      if ($urandom_range(0, 2) == 0) a = AW'(1008 + $urandom_range(0, 15));
      else                           a = AW'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) in_drv = IW'($urandom);
      step(a, 4'($urandom), $urandom, 1'($urandom));
    end

    // Reset coinciding with a write to OUT word 0 cancels it and clears state.
    step(10'h3F2, 4'hF, 32'hA5A5_5A5A, 1'b1);
    reset = 1'b1;
    reset_model();
    step(10'h3F2, 4'hF, 32'hCAFE_F00D, 1'b1);
    chk("reset_mid_write_bus", {12'd0, io_output_bus}, 64'd0);
    chk("reset_mid_write_q", {32'd0, q}, 64'd0);
    reset = 1'b0;
    step(10'h3FF, 4'h0, 32'd0, 1'b0);
    chk("cycle_restart", {32'd0, q}, 64'd0);
    step(10'h3F2, 4'h0, 32'd0, 1'b0);
    chk("out0_after_reset", {32'd0, q}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
